// File: rtl/ahbs_sram_top_if.sv
// AHB-Lite slave-side bus bundle for ahbs_sram_top.
// The master modport is the decoder/mux view; slave is the target view.
interface ahbs_sram_top_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahbs_sram_top.sv
// AHB-Lite SRAM slave: word memory, WAIT_CYC wait states per data phase.
// Define AHBS_SRAM_ERR_EN to build the two-cycle ERROR response.
module ahbs_sram_top #(
  parameter int ADDR_W   = 6,
  parameter int WAIT_CYC = 0
) (
  input  logic           hclk,
  input  logic           hrst_b,
  ahbs_sram_top_if.slave bus
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [1:0] WMAX  = 2'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    DATA
`ifdef AHBS_SRAM_ERR_EN
    , ERR1,
    ERR2
`endif
  } st_t;

  st_t               st, st_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q, err_q;
  logic [31:0]       mem [DEPTH];
  logic              rdy, req, err_in, cap, wr_en;
  logic [1:0]        resp;
  logic [3:0]        be;
  logic [ADDR_W-1:0] widx;
  logic              unused_ok;

  assign req    = bus.hsel & bus.hready & bus.htrans[1];
  assign err_in = (bus.hsize >= 3'd3)
                | (bus.hsize == 3'd1 & bus.haddr[0])
                | (bus.hsize == 3'd2 & |bus.haddr[1:0]);
  assign cap    = rdy & req;
  assign widx   = addr_q[ADDR_W+1:2];
  assign wr_en  = (st == DATA) & rdy & write_q & ~err_q;

  assign unused_ok = ^{bus.hburst, bus.hprot,
                       bus.haddr[31:ADDR_W+2]};

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    rdy    = 1'b1;
    resp   = 2'b00;
    unique case (st)
      DATA: begin
        rdy = (cnt == WMAX);
        if (!rdy) cnt_nx = cnt + 2'd1;
      end
`ifdef AHBS_SRAM_ERR_EN
      ERR1: begin
        rdy   = 1'b0;
        resp  = 2'b01;
        st_nx = ERR2;
      end
      ERR2: resp = 2'b01;
`endif
      default: ;
    endcase
    // every ready point either accepts a new beat or drops to IDLE
    if (rdy) begin
      cnt_nx = '0;
      if (cap) begin
`ifdef AHBS_SRAM_ERR_EN
        st_nx = err_in ? ERR1 : DATA;
`else
        st_nx = DATA;
`endif
      end else begin
        st_nx = IDLE;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      size_q == 2'd0: be = 4'b0001 << addr_q[1:0];
      size_q == 2'd1: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:        be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hrst_b) begin
      st      <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      if (cap) begin
        addr_q  <= bus.haddr[ADDR_W+1:0];
        size_q  <= bus.hsize[1:0];
        write_q <= bus.hwrite;
        err_q   <= err_in;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hreadyout = rdy;
  assign bus.hresp     = resp;
  assign bus.hrdata    = (st == DATA && !write_q && !err_q)
                       ? mem[widx] : 32'b0;
endmodule

// File: tb/tb_ahbs_sram_top.sv
// Bench for ahbs_sram_top: two slaves (0 and 2 wait states) on one bus,
// directed steps plus random single transfers against a byte-level model.
module tb_ahbs_sram_top;
  localparam int W0 = 0;
  localparam int W1 = 2;
`ifdef AHBS_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  ahbs_sram_top_if if0 ();
  ahbs_sram_top_if if1 ();

  logic        sel = 1'b0, hsel = 1'b0, hwrite = 1'b0;
  logic        force_low = 1'b0, dsel = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0, hburst = '0;
  logic        hready;
  logic [31:0] mdl [2][64];

  assign hready = (dsel ? if1.hreadyout : if0.hreadyout) & ~force_low;

  assign if0.hsel   = hsel & (sel == 1'b0);
  assign if1.hsel   = hsel & (sel == 1'b1);
  assign if0.haddr  = haddr;   assign if1.haddr  = haddr;
  assign if0.htrans = htrans;  assign if1.htrans = htrans;
  assign if0.hwrite = hwrite;  assign if1.hwrite = hwrite;
  assign if0.hsize  = hsize;   assign if1.hsize  = hsize;
  assign if0.hburst = hburst;  assign if1.hburst = hburst;
  assign if0.hprot  = 4'h3;    assign if1.hprot  = 4'h3;
  assign if0.hwdata = hwdata;  assign if1.hwdata = hwdata;
  assign if0.hready = hready;  assign if1.hready = hready;

  always @(posedge clk)
    if (!rst_b) dsel <= 1'b0;
    else if (hready) dsel <= sel;

  ahbs_sram_top #(.ADDR_W(6), .WAIT_CYC(W0)) u0 (
    .hclk(clk), .hrst_b(rst_b), .bus(if0));
  ahbs_sram_top #(.ADDR_W(6), .WAIT_CYC(W1)) u1 (
    .hclk(clk), .hrst_b(rst_b), .bus(if1));

  function automatic logic rdy_of(bit d);
    return d ? if1.hreadyout : if0.hreadyout;
  endfunction
  function automatic logic [1:0] resp_of(bit d);
    return d ? if1.hresp : if0.hresp;
  endfunction
  function automatic logic [31:0] rd_of(bit d);
    return d ? if1.hrdata : if0.hrdata;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(logic [2:0] sz, logic [1:0] a);
    return (sz == 3'd0) || (sz == 3'd1 && !a[0]) ||
           (sz == 3'd2 && a == 2'd0);
  endfunction

  // a transfer of 2^sz bytes starting at byte offset a[1:0]
  task automatic mdl_write(bit d, logic [31:0] a, logic [2:0] sz,
                           logic [31:0] wd);
    int w   = int'(a[7:2]);
    int off = int'(a[1:0]);
    int nb  = 1 << sz;
    for (int b = off; b < off + nb; b++)
      mdl[d][w][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic xfer(bit d, logic [31:0] a, bit wr, logic [2:0] sz,
                      logic [31:0] wd, string tag);
    bit          ok     = legal(sz, a[1:0]);
    int          n      = (!ok && ERR_EN) ? 2 : ((d ? W1 : W0) + 1);
    logic [31:0] exp_rd = (wr || !ok) ? 32'h0 : mdl[d][int'(a[7:2])];
    logic [1:0]  exp_rs = (ok || !ERR_EN) ? 2'b00 : 2'b01;
    @(negedge clk);
    sel = d; hsel = 1'b1; htrans = 2'b10; haddr = a;
    hwrite = wr; hsize = sz; hburst = 3'd0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, ".rdy"}, 32'(rdy_of(d)), 32'(k == n - 1));
      chk({tag, ".resp"}, 32'(resp_of(d)), 32'(exp_rs));
    end
    chk({tag, ".rdata"}, rd_of(d), exp_rd);
    if (wr && ok) mdl_write(d, a, sz, wd);
  endtask

  task automatic idle_probe(logic [1:0] t, logic s, logic fl, string tag);
    @(negedge clk);
    sel = 1'b0; hsel = s; htrans = t; haddr = 32'h30;
    hwrite = 1'b1; hsize = 3'd2; force_low = fl;
    @(negedge clk);
    force_low = 1'b0; hsel = 1'b0; htrans = 2'b00;
    hwdata = 32'hBAD0BAD0;
    chk({tag, ".rdy"}, 32'(if0.hreadyout), 32'd1);
    chk({tag, ".resp"}, 32'(if0.hresp), 32'd0);
    chk({tag, ".rdata"}, if0.hrdata, 32'h0);
  endtask

  initial begin
    bit          d, wr;
    int          w, cyc, n;
    logic [1:0]  off;
    logic [2:0]  sz;
    logic [31:0] r, a, wd;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) mdl[i][j] = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst.rdy", 32'(if0.hreadyout), 32'd1);
    chk("rst.resp", 32'(if0.hresp), 32'd0);
    chk("rst.rdata", if0.hrdata, 32'h0);
    rst_b = 1'b1;

    // pipelined write then read of the same word, no stall
    @(negedge clk);
    sel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h10;
    hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    chk("b2b.wr_rdy", 32'(if0.hreadyout), 32'd1);
    mdl_write(1'b0, 32'h10, 3'd2, 32'hDEADBEEF);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b.rd_rdy", 32'(if0.hreadyout), 32'd1);
    chk("b2b.rdata", if0.hrdata, mdl[0][4]);

    xfer(1'b0, 32'h21, 1'b1, 3'd0, {4{8'hAA}}, "byte");
    xfer(1'b0, 32'h22, 1'b1, 3'd1, 32'h12341234, "half");
    xfer(1'b0, 32'h20, 1'b0, 3'd2, 32'h0, "bh_rd");
    chk("bh.model", mdl[0][8], 32'h1234AA00);

    xfer(1'b0, 32'h04, 1'b1, 3'd2, 32'hCAFEF00D, "pre_err");
    xfer(1'b0, 32'h06, 1'b1, 3'd2, 32'h11111111, "err_w");
    xfer(1'b0, 32'h05, 1'b1, 3'd1, 32'h22222222, "err_h");
    xfer(1'b0, 32'h04, 1'b0, 3'd3, 32'h0, "err_sz3");
    xfer(1'b0, 32'h04, 1'b0, 3'd2, 32'h0, "err_chk");

    idle_probe(2'b01, 1'b1, 1'b0, "busy");
    idle_probe(2'b00, 1'b1, 1'b0, "idle");
    idle_probe(2'b10, 1'b0, 1'b0, "nosel");
    idle_probe(2'b10, 1'b1, 1'b1, "hrdy_lo");
    xfer(1'b0, 32'h30, 1'b0, 3'd2, 32'h0, "gate_chk");

    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'(4 * i), 1'b1, 3'd2, $urandom, "w1_fill");
    xfer(1'b1, 32'h8, 1'b0, 3'd2, 32'h0, "wait_rd");

    // INCR4 read burst on the 2-wait slave: 4 beats of 3 cycles
    @(negedge clk);
    sel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd3;
    cyc = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b < 3) begin
        htrans = 2'b11; haddr = 32'(4 * (b + 1));
      end else begin
        hsel = 1'b0; htrans = 2'b00; hburst = 3'd0;
      end
      n = 1;
      while (rdy_of(1'b1) !== 1'b1 && n < 16) begin
        @(negedge clk);
        n++;
      end
      cyc += n;
      chk("burst.rdata", if1.hrdata, mdl[1][b]);
    end
    chk("burst.cycles", 32'(cyc), 32'(4 * (W1 + 1)));

    for (int i = 0; i < 80; i++) begin
      d   = 1'($urandom_range(0, 1));
      w   = $urandom_range(0, 15);
      off = 2'($urandom);
      sz  = 3'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      r   = $urandom;
      wd  = $urandom;
      a   = {r[31:8], w[5:0], off};
      xfer(d, a, wr, sz, wd, "rand");
    end

    // reset while the 2-wait slave is stalling a read
    @(negedge clk);
    sel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h8;
    hwrite = 1'b0; hsize = 3'd2;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    chk("mid.stall", 32'(if1.hreadyout), 32'd0);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.rdy1", 32'(if1.hreadyout), 32'd1);
    chk("mid.resp1", 32'(if1.hresp), 32'd0);
    chk("mid.rdata1", if1.hrdata, 32'h0);
    chk("mid.rdy0", 32'(if0.hreadyout), 32'd1);
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) mdl[i][j] = 32'h0;
    xfer(1'b1, 32'h0, 1'b0, 3'd2, 32'h0, "rst_rd1");
    xfer(1'b1, 32'h8, 1'b0, 3'd2, 32'h0, "rst_rd1b");
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, "rst_rd0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahbs_sram_top.md
# ahbs_sram_top

AHB-Lite slave with a small internal word-organised memory, programmable wait states and a two-cycle ERROR response. It answers transfers from an AHB master such as `ahbm_*` ports. It serves as a bus-functional target for interconnect bring-up and as scratch memory on the SoC matrix.

## Interface
Parameters:
- `ADDR_W`, 6: word-address bits. Depth is 2^ADDR_W words (default 64 words, 256 B).
- `WAIT_CYC`, 0: wait states inserted on every OKAY data phase. Legal range 0–3.

Ports:
- `hclk` in 1: single clock. All logic is on the rising edge.
- `hrst_b` in 1: reset, synchronous, active-low.
- `hsel` in 1: slave select from the decoder.
- `haddr` in 32: address. Only `haddr[ADDR_W+1:0]` is used; upper bits are ignored.
- `htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 0 byte, 1 halfword, 2 word. Values ≥3 are illegal.
- `hburst` in 3: ignored. Each beat is handled independently.
- `hprot` in 4: ignored.
- `hwdata` in 32: write data, sampled during the data phase.
- `hready` in 1: bus-level ready (the mux output).
- `hreadyout` out 1: slave ready.
- `hresp` out 2: 00 OKAY, 01 ERROR.
- `hrdata` out 32: read data.

## Operation
- **Address-phase capture.** On a rising edge where `hsel & hready & htrans[1]`, register `addr_q`, `size_q`, `write_q` and `err_q`. Any other combination on a `hready` edge (IDLE, BUSY, or not selected) moves the slave to IDLE.
- **Illegal transfer (`err_q`).** Any of:
  - `hsize ≥ 3`
  - `hsize==1` and `haddr[0]`
  - `hsize==2` and `haddr[1:0]!=0`
- **State machine** (`st`): IDLE, DATA, ERR1, ERR2.
  - IDLE: `hreadyout=1`, `hresp=00`.
  - Capture of a legal transfer goes to DATA with `cnt=0`. Capture of an illegal transfer goes to ERR1. This applies from IDLE, from a completing DATA, and from ERR2.
  - DATA: `hreadyout = (cnt==WAIT_CYC)`, `hresp=00`. `cnt` increments while `cnt<WAIT_CYC`. The phase completes when `hreadyout=1`.
  - ERR1: `hreadyout=0`, `hresp=01`. Always goes to ERR2.
  - ERR2: `hreadyout=1`, `hresp=01`. A new address phase captured on this edge is accepted.
- **Writes.** On the completing edge of a write DATA phase, `hwdata` byte lanes are written to `mem[addr_q[ADDR_W+1:2]]`:
  - byte: lane `addr_q[1:0]`
  - halfword: lanes {1,0} or {3,2} selected by `addr_q[1]`
  - word: all four lanes
- **Reads.** `hrdata = mem[addr_q[ADDR_W+1:2]]` (full word, all lanes) while `st==DATA & !write_q`. Otherwise `hrdata = 32'b0`.
- **Write followed by read.** A write completing on edge N is visible to a read whose data phase starts at N. No forwarding is needed.
- **ERROR responses.** ERR states never modify memory.

## Timing
- **Reset** (`hrst_b` low at an edge): `st=IDLE`, `cnt=0`, `hreadyout=1`, `hresp=00`, `hrdata=0`, all memory words cleared to 0.
  - Reset mid-transfer abandons the transfer. A write with an incomplete data phase is not committed.
- **Read latency** for zero-wait OKAY transfers: address phase at cycle N, `hrdata` valid and `hreadyout=1` in cycle N+1.
- Each OKAY data phase lasts `1+WAIT_CYC` cycles.
- Each ERROR response lasts exactly 2 cycles.
- While `hreadyout=0`, address-phase inputs are not sampled.
- **Back-to-back transfers** are pipelined: zero-wait throughput is 1 transfer per cycle.
- `hready` low while IDLE (another slave stalling): no capture, state held.

## Configuration
- Macro `AHBS_SRAM_ERR_EN`.
- **Defined:** illegal transfers produce the two-cycle ERROR response described above.
- **Undefined:**
  - ERR1/ERR2 are not built.
  - Illegal transfers go to DATA and complete with OKAY after `WAIT_CYC` waits.
  - Illegal writes are discarded.
  - Illegal reads return `hrdata=0`.

## Test plan
- **Reset.** Assert `hrst_b=0` for 2 cycles mid-read, then read word 0 → `hreadyout=1`, `hresp=00`, read returns `32'h0`.
- **Word write/read.** `WAIT_CYC=0`, NONSEQ write `0x10`/`32'hDEADBEEF`, then NONSEQ read `0x10` in the next cycle → `hrdata=32'hDEADBEEF` one cycle after the read address phase, no stall.
- **Byte and halfword writes.** Byte write `0x21`=`0xAA`, then halfword write `0x22`=`0x1234` over a zeroed word, then read `0x20` → `32'h1234AA00`.
- **Wait states.** `WAIT_CYC=2`, read → `hreadyout` low for 2 cycles, data on the 3rd. An INCR4 burst takes 12 cycles.
- **Error response** (with `AHBS_SRAM_ERR_EN`).
  - Word write to `0x06` → cycle1 `hreadyout=0`/`hresp=01`, cycle2 `hreadyout=1`/`hresp=01`, memory unchanged.
  - Repeat with the macro undefined → OKAY, memory unchanged.
- **Select and hready gating.**
  - BUSY, IDLE and `hsel=0` transfers → no state change, OKAY.
  - `hready=0` from a foreign slave during a valid address → not captured.
